// File: rtl/spike_event_queue.sv
// Spike event queue: accepts per-timestep spike frames (one bit per neuron lane),
// serialises the set lanes into {timestep, neuron_id} events in ascending lane
// order, and buffers them in a DEPTH-entry FIFO for a downstream consumer.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   in_valid/in_ready    frame handshake; in_ready is high only while idle
//   spike_mask           fired lanes of the offered frame
//   base_id, timestep    neuron ID of lane 0 and timestep tag of the frame
//   out_valid/out_ready  event handshake at the FIFO head
//   out_event            {timestep, neuron_id} of the FIFO head (0 when empty)
//   fifo_level           current FIFO occupancy
//   frame_done           one-cycle pulse once a frame has been fully queued
//   spike_count          saturating count of events pushed since reset
module spike_event_queue #(
  parameter int unsigned LANES = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         spike_mask,
  input  logic [15:0]              base_id,
  input  logic [15:0]              timestep,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_event,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_done,
  output logic [15:0]              spike_count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e            state_q, state_d;
  logic [LANES-1:0]  mask_q, mask_d, mask_rest;
  logic [15:0]       base_q, base_d;
  logic [15:0]       ts_q, ts_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       count_q;
  logic [LvlW-1:0]   level_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]       mem_q [DEPTH];

  logic [LaneW-1:0]  lane_idx;
  logic [15:0]       neuron_id;
  logic              pop, push_ok, push;

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (level_q != '0);
  assign pop        = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok    = (level_q < LvlW'(DEPTH)) || pop;
  assign push       = (state_q == StScan) && push_ok;
  // Clears the lowest set bit.
  assign mask_rest  = mask_q & (mask_q - LANES'(1));
  assign neuron_id  = base_q + 16'(lane_idx);

  // Lowest-index set lane of the pending mask.
  always_comb begin
    lane_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_q[i]) lane_idx = LaneW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    base_d       = base_q;
    ts_d         = ts_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mask_d = spike_mask;
          base_d = base_id;
          ts_d   = timestep;
          if (spike_mask == '0) frame_done_d = 1'b1;
          else                  state_d      = StScan;
        end
      end
      StScan: begin
        if (push_ok) begin
          mask_d = mask_rest;
          if (mask_rest == '0) begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      base_q       <= '0;
      ts_q         <= '0;
      frame_done_q <= 1'b0;
      count_q      <= '0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      base_q       <= base_d;
      ts_q         <= ts_d;
      frame_done_q <= frame_done_d;
      if (push && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      level_q <= level_q + LvlW'(1);
      else if (pop && !push) level_q <= level_q - LvlW'(1);
    end
  end

  // Storage needs no reset: entries are only visible through out_event while counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_q, neuron_id};
  end

  // Gating keeps out_event at zero when empty, so a push is never bypassed.
  assign out_event   = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign fifo_level  = level_q;
  assign frame_done  = frame_done_q;
  assign spike_count = count_q;

endmodule
